// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 encodings,
// access sizes, fault bit positions and the FSM state encoding.
package dmem_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int FAULT_MISALIGN = 0;
  localparam int FAULT_ILLEGAL  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response bundle between the MEM stage (master) and dmem_lsu (slave).
interface dmem_lsu_if #(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 32
);
  // A request transfers on a clock edge where req_valid && req_ready; the
  // req_* fields are sampled only then. rsp_valid is a one-cycle pulse with
  // no back-pressure; rsp_rdata/rsp_fault are meaningful only during it.
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [2:0]           req_funct3;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [XLEN-1:0]      req_wdata;
  logic [ADDR_SIZE-1:0] req_pc;
  logic                 rsp_valid;
  logic [XLEN-1:0]      rsp_rdata;
  logic [1:0]           rsp_fault;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_pc,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_pc,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/dmem_lsu_align.sv
// lsu_align: combinational byte-lane enables, store replication, fault
// detection for the incoming request, and load extraction for the captured one.
module lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [1:0]  fault,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    fault = 2'b00;
    be        = 4'b1111;
    wdata_rep = wdata;
    unique case (funct3[1:0])
      SZ_BYTE: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be                    = 4'b0011 << {off[1], 1'b0};
        wdata_rep             = {2{wdata[15:0]}};
        fault[FAULT_MISALIGN] = off[0];
      end
      SZ_WORD: fault[FAULT_MISALIGN] = |off;
      default: ;
    endcase
    // Stores have no unsigned variants, so any funct3[2] is illegal for them.
    if (we) fault[FAULT_ILLEGAL] = funct3[2] | (funct3 == 3'b011);
    else    fault[FAULT_ILLEGAL] = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);
  end

  always_comb begin
    shifted = ld_word >> {ld_off, 3'b000};
    ld_data = shifted;
    unique case (ld_funct3[1:0])
      SZ_BYTE: ld_data = ld_funct3[2] ? {24'b0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: ld_data = ld_funct3[2] ? {16'b0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: synchronous-read data RAM with load/store FSM and registered read
// path. Define DMEM_LSU_TRACE_EN to print a trace line for every committed store.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_SIZE   = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int READ_LAT    = 1
) (
  input  logic       clk,
  input  logic       reset,
  dmem_lsu_if.slave  bus,
  output lsu_state_e dbg_state
);

  localparam int IW = $clog2(DEPTH_WORDS);

  lsu_state_e      state, state_n;
  logic [XLEN-1:0] mem [DEPTH_WORDS];
  logic [IW-1:0]   idx;
  logic            accept, st_commit, ld_accept;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata_rep, ld_word, ld_data;
  logic [1:0]      fault;
  logic [1:0]      ld_off_q;
  logic [2:0]      ld_f3_q;
  logic [1:0]      ld_fault_q;
  logic [XLEN-1:0] rd_word_q, rd_pipe_q;
  logic [XLEN-1:0] rsp_rdata_q;
  logic [1:0]      rsp_fault_q;

  assign idx       = bus.req_addr[2 +: IW];
  assign accept    = bus.req_valid && bus.req_ready;
  assign st_commit = accept && bus.req_we && (fault == 2'b00);
  assign ld_accept = accept && !bus.req_we;
  assign ld_word   = (READ_LAT == 2) ? rd_pipe_q : rd_word_q;

  assign bus.req_ready = (state == IDLE) && !reset;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign dbg_state     = state;

  lsu_align u_align (
    .we        (bus.req_we),
    .funct3    (bus.req_funct3),
    .off       (bus.req_addr[1:0]),
    .wdata     (bus.req_wdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .fault     (fault),
    .ld_funct3 (ld_f3_q),
    .ld_off    (ld_off_q),
    .ld_word   (ld_word),
    .ld_data   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = bus.req_we ? RESP : RD1;
      RD1:     state_n = (READ_LAT == 1) ? RESP : RD2;
      RD2:     state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Array is deliberately left uncleared; writes are already blocked during
  // reset because req_ready is low.
  always_ff @(posedge clk) begin
    if (st_commit) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
    end
    if (ld_accept) rd_word_q <= mem[idx];
    rd_pipe_q <= rd_word_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_off_q    <= '0;
      ld_f3_q     <= '0;
      ld_fault_q  <= '0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= '0;
    end else begin
      if (accept) begin
        ld_off_q   <= bus.req_addr[1:0];
        ld_f3_q    <= bus.req_funct3;
        ld_fault_q <= fault;
        if (bus.req_we) begin
          rsp_rdata_q <= '0;
          rsp_fault_q <= fault;
        end
      end
      if ((state == RD1 || state == RD2) && state_n == RESP) begin
        rsp_fault_q <= ld_fault_q;
        rsp_rdata_q <= (ld_fault_q != 2'b00) ? '0 : ld_data;
      end
    end
  end

`ifdef DMEM_LSU_TRACE_EN
  logic [XLEN-1:0] trace_word;

  always_comb begin
    trace_word = mem[idx];
    for (int i = 0; i < 4; i++)
      if (be[i]) trace_word[8*i +: 8] = wdata_rep[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (st_commit)
      $display("pc = %h: dataaddr = %h, memdata = %h",
               bus.req_pc, {bus.req_addr[ADDR_SIZE-1:2], 2'b00}, trace_word);
  end
`else
  logic unused_ok;
  assign unused_ok = ^{bus.req_pc, bus.req_addr[ADDR_SIZE-1:2+IW]};
`endif

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: two instances (READ_LAT 1 and 2) driven in lockstep and
// checked against a byte-addressed reference memory.
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, req_pc;
  lsu_state_e  st1, st2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  mb [4096];

  always #5 clk = ~clk;

  dmem_lsu_if #(.XLEN(32), .ADDR_SIZE(32)) if1 ();
  dmem_lsu_if #(.XLEN(32), .ADDR_SIZE(32)) if2 ();

  assign if1.req_valid = req_valid;  assign if2.req_valid = req_valid;
  assign if1.req_we = req_we;        assign if2.req_we = req_we;
  assign if1.req_funct3 = req_funct3; assign if2.req_funct3 = req_funct3;
  assign if1.req_addr = req_addr;    assign if2.req_addr = req_addr;
  assign if1.req_wdata = req_wdata;  assign if2.req_wdata = req_wdata;
  assign if1.req_pc = req_pc;        assign if2.req_pc = req_pc;

  dmem_lsu #(.XLEN(32), .ADDR_SIZE(32), .DEPTH_WORDS(1024), .READ_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave), .dbg_state(st1));
  dmem_lsu #(.XLEN(32), .ADDR_SIZE(32), .DEPTH_WORDS(1024), .READ_LAT(2)) u_dut2 (
    .clk(clk), .reset(reset), .bus(if2.slave), .dbg_state(st2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: byte-addressed memory of 4096 bytes (1024 words, wraps).
  function automatic logic [1:0] ref_fault(input logic we, input logic [2:0] f3,
                                           input logic [31:0] a);
    logic mis, ill;
    mis = (f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0);
    if (we) ill = f3[2] || f3 == 3'd3;
    else    ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    return {ill, mis};
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int nb, base;
    if (ref_fault(1'b1, f3, a) != 2'b00) return;
    nb   = 1 << f3[1:0];
    base = int'(a[11:0]);
    for (int i = 0; i < nb; i++) mb[base + i] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int nb, base;
    if (ref_fault(1'b0, f3, a) != 2'b00) return 32'h0;
    nb   = 1 << f3[1:0];
    base = int'(a[11:0]);
    v    = 32'h0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[base + i];
    if (!f3[2] && nb < 4)
      for (int j = 8*nb; j < 32; j++) v[j] = v[8*nb - 1];
    return v;
  endfunction

  // One transaction issued to both instances; checks latency, data and fault.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    int k, lat1, lat2;
    logic [31:0] d1, d2, exp_d;
    logic [1:0]  f1, f2, exp_f;
    check("ready1_idle", {31'b0, if1.req_ready}, 32'd1);
    check("ready2_idle", {31'b0, if2.req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    req_pc = $urandom;
    exp_f = ref_fault(we, f3, a);
    exp_d = we ? 32'h0 : model_load(f3, a);
    if (we) model_store(f3, a, wd);
    exp_q.push_back(exp_d);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat1 = 0; lat2 = 0; k = 0;
    d1 = 'x; d2 = 'x; f1 = 'x; f2 = 'x;
    forever begin
      if (if1.rsp_valid && lat1 == 0) begin lat1 = k + 1; d1 = if1.rsp_rdata; f1 = if1.rsp_fault; end
      if (if2.rsp_valid && lat2 == 0) begin lat2 = k + 1; d2 = if2.rsp_rdata; f2 = if2.rsp_fault; end
      if ((lat1 != 0 && lat2 != 0) || k == 8) break;
      @(posedge clk); #1;
      k++;
    end
    exp_d = exp_q.pop_front();
    check("lat1", lat1, we ? 32'd1 : 32'd2);
    check("lat2", lat2, we ? 32'd1 : 32'd3);
    check("rdata1", d1, exp_d);
    check("rdata2", d2, exp_d);
    check("fault1", {30'b0, f1}, {30'b0, exp_f});
    check("fault2", {30'b0, f2}, {30'b0, exp_f});
    @(posedge clk); #1;
    check("rsp1_pulse_end", {31'b0, if1.rsp_valid}, 32'd0);
    check("rsp2_pulse_end", {31'b0, if2.rsp_valid}, 32'd0);
  endtask

  // Hold one request continuously for 24 cycles and count accepts/responses.
  task automatic throughput(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input int exp1, input int exp2);
    int a1, a2, r1, r2;
    a1 = 0; a2 = 0; r1 = 0; r2 = 0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    if (we) model_store(f3, a, wd);
    repeat (24) begin
      @(negedge clk);
      if (if1.req_ready) a1++;
      if (if2.req_ready) a2++;
      if (if1.rsp_valid) r1++;
      if (if2.rsp_valid) r2++;
    end
    req_valid = 1'b0;
    check(we ? "st_accepts1" : "ld_accepts1", a1, exp1);
    check(we ? "st_accepts2" : "ld_accepts2", a2, exp2);
    check(we ? "st_rsps1" : "ld_rsps1", r1, exp1);
    check(we ? "st_rsps2" : "ld_rsps2", r2, exp2);
    repeat (4) @(posedge clk);
    #1;
    check("drain_state1", {30'b0, st1}, {30'b0, IDLE});
    check("drain_state2", {30'b0, st2}, {30'b0, IDLE});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    logic [31:0] a;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = '0; req_wdata = '0; req_pc = '0;

    // Reset values
    @(posedge clk); @(posedge clk); #1;
    check("rst_ready1", {31'b0, if1.req_ready}, 32'd0);
    check("rst_ready2", {31'b0, if2.req_ready}, 32'd0);
    check("rst_rsp_valid1", {31'b0, if1.rsp_valid}, 32'd0);
    check("rst_rdata1", if1.rsp_rdata, 32'd0);
    check("rst_fault2", {30'b0, if2.rsp_fault}, 32'd0);
    check("rst_state1", {30'b0, st1}, {30'b0, IDLE});
    reset = 1'b0;
    #1;
    check("post_rst_ready1", {31'b0, if1.req_ready}, 32'd1);
    @(posedge clk); #1;

    // Store then sign/zero-extended loads
    do_req(1'b1, F3_SW, 32'h10, 32'h8000_00FF);
    do_req(1'b0, F3_LB, 32'h10, 32'h0);
    do_req(1'b0, F3_LBU, 32'h10, 32'h0);
    do_req(1'b0, F3_LW, 32'h10, 32'h0);

    // Partial-lane merges
    do_req(1'b1, F3_SW, 32'h20, 32'h0);
    do_req(1'b1, F3_SB, 32'h22, 32'hFFFF_FFAB);
    do_req(1'b1, F3_SH, 32'h20, 32'hCDEF_1234);
    do_req(1'b0, F3_LW, 32'h20, 32'h0);
    do_req(1'b0, F3_LH, 32'h22, 32'h0);
    do_req(1'b0, F3_LHU, 32'h20, 32'h0);

    // Store faults leave memory untouched
    do_req(1'b1, F3_SW, 32'h24, 32'h1111_1111);
    do_req(1'b1, F3_SH, 32'h21, 32'hFFFF_FFFF);
    do_req(1'b0, F3_LW, 32'h20, 32'h0);
    do_req(1'b1, 3'b110, 32'h24, 32'hFFFF_FFFF);
    do_req(1'b1, 3'b110, 32'h25, 32'hFFFF_FFFF);
    do_req(1'b0, F3_LW, 32'h24, 32'h0);

    // Load faults
    do_req(1'b0, 3'b011, 32'h24, 32'h0);
    do_req(1'b0, F3_LW, 32'h26, 32'h0);
    do_req(1'b0, 3'b110, 32'h27, 32'h0);

    // Throughput with req_valid held high
    throughput(1'b0, F3_LW, 32'h10, 32'h0, 8, 6);
    throughput(1'b1, F3_SW, 32'h40, 32'h0BAD_F00D, 12, 12);
    do_req(1'b0, F3_LW, 32'h40, 32'h0);

    // Reset while both instances sit in RD1
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_LW; req_addr = 32'h20;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_ready1", {31'b0, if1.req_ready}, 32'd0);
    check("midrst_ready2", {31'b0, if2.req_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("after_rst_ready1", {31'b0, if1.req_ready}, 32'd1);
    check("after_rst_ready2", {31'b0, if2.req_ready}, 32'd1);
    pulses = 0;
    repeat (4) begin
      if (if1.rsp_valid || if2.rsp_valid) pulses++;
      @(posedge clk); #1;
    end
    check("dropped_rsp", pulses, 32'd0);
    do_req(1'b0, F3_LW, 32'h20, 32'h0);

    // Store presented while reset is high is not written
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_SW;
    req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0;
    #1;
    check("rst_store_no_rsp", {31'b0, if1.rsp_valid | if2.rsp_valid}, 32'd0);
    do_req(1'b0, F3_LW, 32'h20, 32'h0);

    // Index wrap
    do_req(1'b1, F3_SW, 32'h1000, 32'h5A5A_5A5A);
    do_req(1'b0, F3_LW, 32'h0, 32'h0);

    // Randomized traffic over an initialised window
    for (int i = 0; i < 16; i++) do_req(1'b1, F3_SW, 32'h100 + 32'(4*i), $urandom);
    for (int i = 0; i < 80; i++) begin
      a = 32'h100 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 3)) << 12);
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
